// File: rtl/insn_loader_pkg.sv
// Shared definitions for the instruction loader: default instruction geometry,
// header length and the loader state encoding.
package insn_loader_pkg;

  localparam int LEN_INSN      = 16;
  localparam int MEM_INSN_ADDR = 8;
  localparam int HDR_LEN       = 2;

  typedef enum logic [2:0] {
    ST_HDR_LO,
    ST_HDR_HI,
    ST_LOAD,
    ST_CHECK,
    ST_DONE,
    ST_ERROR
  } loader_state_t;

  // The loader only refuses bytes once a load has finished, good or bad.
  function automatic logic is_stalled(input loader_state_t s);
    return (s == ST_DONE) || (s == ST_ERROR);
  endfunction

  // Total bytes in a stream carrying n_words words of bpw bytes each.
  function automatic int stream_len(input int n_words, input int bpw);
    return HDR_LEN + n_words * bpw + 1;
  endfunction

endpackage

// File: rtl/insn_loader_assembler.sv
// Collects little-endian stream bytes into instruction words; word_done and
// word are valid in the same cycle as the last byte of a word.
module insn_loader_assembler
  import insn_loader_pkg::*;
#(
  parameter int WORD_BITS = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  input  logic                 byte_valid,
  input  logic [7:0]           byte_data,
  output logic                 word_done,
  output logic [WORD_BITS-1:0] word
);

  localparam int BPW = WORD_BITS / 8;
  localparam int CW  = (BPW > 1) ? $clog2(BPW) : 1;
  localparam logic [CW-1:0] LAST_BYTE = CW'(BPW - 1);

  logic [CW-1:0] byte_cnt;

  assign word_done = byte_valid && (byte_cnt == LAST_BYTE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      byte_cnt <= '0;
    end else if (clear) begin
      byte_cnt <= '0;
    end else if (byte_valid) begin
      if (byte_cnt == LAST_BYTE) byte_cnt <= '0;
      else                       byte_cnt <= byte_cnt + 1'b1;
    end
  end

  generate
    if (BPW == 1) begin : g_single
      assign word = byte_data;
    end else begin : g_multi
      // Earlier bytes of the word slide down so the first one lands in bits [7:0].
      logic [WORD_BITS-9:0] shreg;

      assign word = {byte_data, shreg};

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          shreg <= '0;
        end else if (clear) begin
          shreg <= '0;
        end else if (byte_valid) begin
          shreg <= word[WORD_BITS-1:8];
        end
      end
    end
  endgenerate

endmodule

// File: rtl/insn_loader.sv
// Writer side of instruction memory: parses a counted, XOR-checked byte stream
// and writes the assembled words from address 0, then releases the pipeline.
module insn_loader #(
  parameter int LEN_INSN      = insn_loader_pkg::LEN_INSN,
  parameter int MEM_INSN_ADDR = insn_loader_pkg::MEM_INSN_ADDR
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     valid_i,
  output logic                     stall_o,
  input  logic [7:0]               data_i,
  input  logic                     start_i,
  output logic                     we_o,
  output logic [MEM_INSN_ADDR-1:0] waddr_o,
  output logic [LEN_INSN-1:0]      wdata_o,
  output logic                     run_o,
  output logic                     err_o
);

  import insn_loader_pkg::*;

  localparam int DEPTH = 2 ** MEM_INSN_ADDR;
  localparam logic [16:0] DEPTH_W = 17'(DEPTH);

  loader_state_t            state;
  logic [7:0]               cnt_lo;
  logic [15:0]              n_words;
  logic [MEM_INSN_ADDR:0]   word_cnt;
  logic [7:0]               checksum;
  logic                     accept;
  logic                     load_byte;
  logic                     rearm;
  logic                     word_done;
  logic [LEN_INSN-1:0]      asm_word;
  logic [16:0]              hdr_count;
  logic [16:0]              next_word_cnt;

  assign stall_o       = is_stalled(state);
  assign accept        = valid_i && !stall_o;
  assign load_byte     = accept && (state == ST_LOAD);
  assign rearm         = start_i && stall_o;
  assign hdr_count     = {1'b0, data_i, cnt_lo};
  assign next_word_cnt = 17'(word_cnt) + 17'd1;

  insn_loader_assembler #(
    .WORD_BITS (LEN_INSN)
  ) u_assembler (
    .clk        (clk),
    .rst        (rst),
    .clear      (rearm),
    .byte_valid (load_byte),
    .byte_data  (data_i),
    .word_done  (word_done),
    .word       (asm_word)
  );

  // Word counter is one bit wider than the address so a full-depth program
  // terminates without the write address ever wrapping.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_HDR_LO;
      cnt_lo   <= '0;
      n_words  <= '0;
      word_cnt <= '0;
      checksum <= '0;
      we_o     <= 1'b0;
      waddr_o  <= '0;
      wdata_o  <= '0;
      run_o    <= 1'b0;
      err_o    <= 1'b0;
    end else begin
      we_o <= 1'b0;
      case (state)
        ST_HDR_LO: begin
          if (accept) begin
            cnt_lo   <= data_i;
            checksum <= checksum ^ data_i;
            state    <= ST_HDR_HI;
          end
        end
        ST_HDR_HI: begin
          if (accept) begin
            n_words  <= {data_i, cnt_lo};
            checksum <= checksum ^ data_i;
            if (hdr_count > DEPTH_W) begin
              state <= ST_ERROR;
              err_o <= 1'b1;
            end else if (hdr_count == 17'd0) begin
              state <= ST_CHECK;
            end else begin
              state <= ST_LOAD;
            end
          end
        end
        ST_LOAD: begin
          if (accept) begin
            checksum <= checksum ^ data_i;
            if (word_done) begin
              we_o     <= 1'b1;
              wdata_o  <= asm_word;
              waddr_o  <= word_cnt[MEM_INSN_ADDR-1:0];
              word_cnt <= word_cnt + 1'b1;
              if (next_word_cnt == {1'b0, n_words}) state <= ST_CHECK;
            end
          end
        end
        ST_CHECK: begin
          if (accept) begin
            if (data_i == checksum) begin
              state <= ST_DONE;
              run_o <= 1'b1;
            end else begin
              state <= ST_ERROR;
              err_o <= 1'b1;
            end
          end
        end
        ST_DONE, ST_ERROR: begin
          if (start_i) begin
            state    <= ST_HDR_LO;
            run_o    <= 1'b0;
            err_o    <= 1'b0;
            cnt_lo   <= '0;
            n_words  <= '0;
            word_cnt <= '0;
            checksum <= '0;
            waddr_o  <= '0;
          end
        end
        default: state <= ST_HDR_LO;
      endcase
    end
  end

endmodule

// File: tb/tb_insn_loader.sv
// Directed bench for insn_loader: table of complete streams plus hand-written
// sequences for gaps, re-arm, full-depth load and mid-stream reset.
module tb_insn_loader;

  import insn_loader_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_i;
  logic        stall_o;
  logic [7:0]  data_i;
  logic        start_i;
  logic        we_o;
  logic [7:0]  waddr_o;
  logic [15:0] wdata_o;
  logic        run_o;
  logic        err_o;

  int checks = 0;
  int errors = 0;

  int          wr_cnt = 0;
  logic [7:0]  wr_addr [1024];
  logic [15:0] wr_data [1024];

  typedef struct {
    string       name;
    int          len;
    logic [7:0]  bytes [8];
    int          n_wr;
    logic [7:0]  addr [3];
    logic [15:0] data [3];
    logic        run;
    logic        err;
  } vec_t;

  vec_t vecs [7];

  insn_loader #(
    .LEN_INSN      (16),
    .MEM_INSN_ADDR (8)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .valid_i (valid_i),
    .stall_o (stall_o),
    .data_i  (data_i),
    .start_i (start_i),
    .we_o    (we_o),
    .waddr_o (waddr_o),
    .wdata_o (wdata_o),
    .run_o   (run_o),
    .err_o   (err_o)
  );

  always #5 clk = ~clk;

  // Log every memory write seen on the falling edge.
  always @(negedge clk) begin
    if (we_o === 1'b1) begin
      if (wr_cnt < 1024) begin
        wr_addr[wr_cnt] = waddr_o;
        wr_data[wr_cnt] = wdata_o;
      end
      wr_cnt++;
    end
  end

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gaps);
    int guard;
    for (int g = 0; g < gaps; g++) begin
      @(negedge clk);
      valid_i = 1'b0;
      data_i  = 8'($urandom);
    end
    @(negedge clk);
    valid_i = 1'b1;
    data_i  = b;
    guard   = 0;
    while (stall_o !== 1'b0 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 20) begin
      checks++;
      errors++;
      $display("[TB] FAIL accept_timeout: stall_o stuck at %b, required 0", stall_o);
    end
    @(posedge clk);
    #1;
    valid_i = 1'b0;
  endtask

  task automatic rearm();
    @(negedge clk);
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    check_output("rearm_run", 32'(run_o), 32'd0);
    check_output("rearm_err", 32'(err_o), 32'd0);
    check_output("rearm_stall", 32'(stall_o), 32'd0);
  endtask

  task automatic apply_stimulus(input vec_t v);
    int base;
    base = wr_cnt;
    for (int i = 0; i < v.len; i++) send_byte(v.bytes[i], 0);
    @(negedge clk);
    check_output({v.name, "_run"}, 32'(run_o), 32'(v.run));
    check_output({v.name, "_err"}, 32'(err_o), 32'(v.err));
    check_output({v.name, "_stall"}, 32'(stall_o), 32'd1);
    repeat (2) @(negedge clk);
    check_output({v.name, "_nwr"}, 32'(wr_cnt - base), 32'(v.n_wr));
    for (int i = 0; i < v.n_wr && i < 3; i++) begin
      check_output({v.name, "_addr"}, 32'(wr_addr[base + i]), 32'(v.addr[i]));
      check_output({v.name, "_data"}, 32'(wr_data[base + i]), 32'(v.data[i]));
    end
  endtask

  task automatic send_normal(input int max_gap);
    logic [7:0] s [7];
    s = '{8'h02, 8'h00, 8'h34, 8'h12, 8'h78, 8'h56, 8'h0A};
    for (int i = 0; i < 7; i++) send_byte(s[i], (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0);
  endtask

  task automatic check_normal_writes(input string name, input int base);
    check_output({name, "_nwr"}, 32'(wr_cnt - base), 32'd2);
    check_output({name, "_addr0"}, 32'(wr_addr[base]), 32'h00);
    check_output({name, "_data0"}, 32'(wr_data[base]), 32'h1234);
    check_output({name, "_addr1"}, 32'(wr_addr[base + 1]), 32'h01);
    check_output({name, "_data1"}, 32'(wr_data[base + 1]), 32'h5678);
  endtask

  initial begin
    int         base;
    int         bad;
    logic [7:0] chk;
    logic [7:0] lo;
    logic [7:0] hi;

    vecs[0] = '{name: "normal", len: 7, bytes: '{8'h02, 8'h00, 8'h34, 8'h12, 8'h78, 8'h56, 8'h0A, 8'h00},
                n_wr: 2, addr: '{8'h00, 8'h01, 8'h00}, data: '{16'h1234, 16'h5678, 16'h0000},
                run: 1'b1, err: 1'b0};
    vecs[1] = '{name: "empty", len: 3, bytes: '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
                n_wr: 0, addr: '{8'h00, 8'h00, 8'h00}, data: '{16'h0000, 16'h0000, 16'h0000},
                run: 1'b1, err: 1'b0};
    vecs[2] = '{name: "badchk", len: 7, bytes: '{8'h02, 8'h00, 8'h34, 8'h12, 8'h78, 8'h56, 8'h0B, 8'h00},
                n_wr: 2, addr: '{8'h00, 8'h01, 8'h00}, data: '{16'h1234, 16'h5678, 16'h0000},
                run: 1'b0, err: 1'b1};
    vecs[3] = '{name: "after_bad", len: 7, bytes: '{8'h02, 8'h00, 8'h34, 8'h12, 8'h78, 8'h56, 8'h0A, 8'h00},
                n_wr: 2, addr: '{8'h00, 8'h01, 8'h00}, data: '{16'h1234, 16'h5678, 16'h0000},
                run: 1'b1, err: 1'b0};
    vecs[4] = '{name: "oversize", len: 2, bytes: '{8'h01, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
                n_wr: 0, addr: '{8'h00, 8'h00, 8'h00}, data: '{16'h0000, 16'h0000, 16'h0000},
                run: 1'b0, err: 1'b1};
    vecs[5] = '{name: "one_word", len: 5, bytes: '{8'h01, 8'h00, 8'hCD, 8'hAB, 8'h67, 8'h00, 8'h00, 8'h00},
                n_wr: 1, addr: '{8'h00, 8'h00, 8'h00}, data: '{16'hABCD, 16'h0000, 16'h0000},
                run: 1'b1, err: 1'b0};
    vecs[6] = '{name: "three_words", len: 8, bytes: '{8'h03, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66},
                n_wr: 0, addr: '{8'h00, 8'h00, 8'h00}, data: '{16'h0000, 16'h0000, 16'h0000},
                run: 1'b0, err: 1'b0};

    rst     = 1'b0;
    valid_i = 1'b0;
    start_i = 1'b0;
    data_i  = 8'h00;
    repeat (2) @(negedge clk);
    check_output("reset_we", 32'(we_o), 32'd0);
    check_output("reset_waddr", 32'(waddr_o), 32'd0);
    check_output("reset_wdata", 32'(wdata_o), 32'd0);
    check_output("reset_run", 32'(run_o), 32'd0);
    check_output("reset_err", 32'(err_o), 32'd0);
    check_output("reset_stall", 32'(stall_o), 32'd0);
    rst = 1'b1;

    for (int i = 0; i < 6; i++) begin
      if (i > 0) rearm();
      apply_stimulus(vecs[i]);
    end

    // Three words, CHK sent separately since it does not fit the 8-byte record.
    rearm();
    base = wr_cnt;
    for (int i = 0; i < 8; i++) send_byte(vecs[6].bytes[i], 0);
    send_byte(8'h74, 0);
    @(negedge clk);
    check_output("three_run", 32'(run_o), 32'd1);
    repeat (2) @(negedge clk);
    check_output("three_nwr", 32'(wr_cnt - base), 32'd3);
    check_output("three_addr2", 32'(wr_addr[base + 2]), 32'h02);
    check_output("three_data0", 32'(wr_data[base]), 32'h2211);
    check_output("three_data1", 32'(wr_data[base + 1]), 32'h4433);
    check_output("three_data2", 32'(wr_data[base + 2]), 32'h6655);

    // Oversize header, then bytes offered in ERROR must be refused.
    rearm();
    base = wr_cnt;
    send_byte(8'h01, 0);
    send_byte(8'h01, 0);
    @(negedge clk);
    valid_i = 1'b1;
    data_i  = 8'h55;
    repeat (4) @(negedge clk);
    check_output("over_stall", 32'(stall_o), 32'd1);
    check_output("over_err", 32'(err_o), 32'd1);
    valid_i = 1'b0;
    check_output("over_nwr", 32'(wr_cnt - base), 32'd0);

    // Full-depth program: N == DEPTH is legal and ends on address 255.
    rearm();
    base = wr_cnt;
    chk  = 8'h00 ^ 8'h01;
    send_byte(8'h00, 0);
    send_byte(8'h01, 0);
    for (int i = 0; i < 256; i++) begin
      lo  = 8'(i);
      hi  = ~lo;
      chk = chk ^ lo ^ hi;
      send_byte(lo, 0);
      send_byte(hi, 0);
    end
    send_byte(chk, 0);
    @(negedge clk);
    check_output("full_run", 32'(run_o), 32'd1);
    check_output("full_err", 32'(err_o), 32'd0);
    repeat (2) @(negedge clk);
    check_output("full_nwr", 32'(wr_cnt - base), 32'd256);
    check_output("full_last_waddr", 32'(waddr_o), 32'hFF);
    bad = 0;
    for (int i = 0; i < 256; i++) begin
      lo = 8'(i);
      if (wr_addr[base + i] !== lo || wr_data[base + i] !== {~lo, lo}) bad++;
    end
    check_output("full_words_bad", 32'(bad), 32'd0);
    check_output("full_len", 32'(stream_len(256, 2)), 32'(4 + wr_cnt - base + 256 - 1));

    // Random valid gaps, start_i asserted outside DONE/ERROR must be ignored.
    rearm();
    base    = wr_cnt;
    start_i = 1'b1;
    begin
      logic [7:0] s [7];
      s = '{8'h02, 8'h00, 8'h34, 8'h12, 8'h78, 8'h56, 8'h0A};
      for (int i = 0; i < 7; i++) begin
        if (i == 6) start_i = 1'b0;
        send_byte(s[i], int'($urandom_range(0, 3)));
      end
    end
    @(negedge clk);
    check_output("gaps_run", 32'(run_o), 32'd1);
    repeat (2) @(negedge clk);
    check_normal_writes("gaps", base);

    // Valid held high in DONE: nothing accepted, nothing written.
    base    = wr_cnt;
    valid_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      data_i = 8'($urandom);
      @(negedge clk);
    end
    check_output("done_hold_stall", 32'(stall_o), 32'd1);
    check_output("done_hold_run", 32'(run_o), 32'd1);
    valid_i = 1'b0;
    check_output("done_hold_nwr", 32'(wr_cnt - base), 32'd0);

    // start_i together with valid_i: the byte must not become CNT_LO.
    @(negedge clk);
    start_i = 1'b1;
    valid_i = 1'b1;
    data_i  = 8'h02;
    @(negedge clk);
    start_i = 1'b0;
    valid_i = 1'b0;
    base    = wr_cnt;
    send_normal(0);
    @(negedge clk);
    check_output("start_valid_run", 32'(run_o), 32'd1);
    check_output("start_valid_err", 32'(err_o), 32'd0);
    repeat (2) @(negedge clk);
    check_normal_writes("start_valid", base);

    // Reset mid-stream, then a full reload.
    rearm();
    send_byte(8'h02, 0);
    send_byte(8'h00, 0);
    send_byte(8'h34, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_output("midrst_we", 32'(we_o), 32'd0);
    check_output("midrst_waddr", 32'(waddr_o), 32'd0);
    check_output("midrst_wdata", 32'(wdata_o), 32'd0);
    check_output("midrst_run", 32'(run_o), 32'd0);
    check_output("midrst_err", 32'(err_o), 32'd0);
    @(negedge clk);
    rst  = 1'b1;
    base = wr_cnt;
    send_normal(0);
    @(negedge clk);
    check_output("midrst_reload_run", 32'(run_o), 32'd1);
    repeat (2) @(negedge clk);
    check_normal_writes("midrst_reload", base);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
